// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder: op encoding and default geometry.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

endpackage

// File: rtl/adder_slice.sv
// One CW-bit chunk of the ripple: purely combinational a + b + cin.
module adder_slice #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract split into STAGES chunk-wide stages; one chunk summed per stage,
// carry registered between stages, operands skewed forward alongside the partial sum.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CW = WIDTH / STAGES;

  typedef logic [STAGES-1:0][WIDTH-1:0] word_arr_t;

  // Handshake: a transfer happens on any rising edge where valid && ready on
  // that side. The whole pipe advances together (adv); stalls hold every stage,
  // bubbles included, and in_ready is adv with no registered slack.
  logic adv;
  logic is_sub;

  word_arr_t         a_q, a_d, bp_q, bp_d, sum_q, sum_d;
  word_arr_t         src_a, src_bp, src_sum;
  logic [STAGES-1:0] valid_q, valid_d, carry_q, carry_d;
  logic [STAGES-1:0] src_cin, src_valid;

  logic [STAGES-1:0][CW-1:0] slice_a, slice_b, slice_sum;
  logic [STAGES-1:0]         slice_cout;

  logic ovf_q, ovf_d, zero_q, zero_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign is_sub   = in_valid && (in_sub == OP_SUB);

  // Stage inputs: stage 0 takes the new op (gated to zero on bubbles), later stages their predecessor.
  always_comb begin
    src_a     = '0;
    src_bp    = '0;
    src_sum   = '0;
    src_cin   = '0;
    src_valid = '0;
    slice_a   = '0;
    slice_b   = '0;

    src_a[0]     = in_valid ? in_a : '0;
    src_bp[0]    = in_valid ? (is_sub ? ~in_b : in_b) : '0;
    src_cin[0]   = is_sub;
    src_valid[0] = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      src_a[k]     = a_q[k-1];
      src_bp[k]    = bp_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_cin[k]   = carry_q[k-1];
      src_valid[k] = valid_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice_a[k] = src_a[k][k*CW +: CW];
      slice_b[k] = src_bp[k][k*CW +: CW];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : gen_slice
    adder_slice #(.CW(CW)) u_slice (
      .a_i   (slice_a[g]),
      .b_i   (slice_b[g]),
      .cin_i (src_cin[g]),
      .sum_o (slice_sum[g]),
      .cout_o(slice_cout[g])
    );
  end

  always_comb begin
    a_d     = src_a;
    bp_d    = src_bp;
    sum_d   = src_sum;
    carry_d = slice_cout;
    valid_d = src_valid;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k][k*CW +: CW] = slice_sum[k];
    end
    // Flags come from the completed sum entering the last stage register.
    ovf_d  = (a_d[STAGES-1][WIDTH-1] == bp_d[STAGES-1][WIDTH-1]) &&
             (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
    zero_d = (sum_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      bp_q    <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bp_q    <= bp_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_carry = carry_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values are 8 to 64.
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0 is required, and the chunk width CW = WIDTH/STAGES.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 in_valid  in  1  operands and op present this cycle.
REQ-006 in_ready  out  1  block accepts the input this cycle.
REQ-007 in_a  in  WIDTH  operand A.
REQ-008 in_b  in  WIDTH  operand B.
REQ-009 in_sub  in  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_sum  out  WIDTH  result, modulo 2^WIDTH.
REQ-013 out_carry  out  1  carry out of the MSB; for subtraction 1 means no borrow (A >= B unsigned).
REQ-014 out_ovf  out  1  signed two's-complement overflow.
REQ-015 out_zero  out  1  out_sum == 0.

Function
REQ-016 Subtraction is computed as A + ~B + 1; addition uses carry-in 0.
REQ-017 Stage k (0..STAGES-1) adds chunk k (bits k*CW+CW-1 : k*CW) using the carry registered from stage k-1; stage 0 uses the op carry-in.
REQ-018 Upper chunks and the op bit are carried forward in skew registers; bits already summed are held alongside.
REQ-019 A transfer occurs when in_valid && in_ready; result latency is exactly STAGES cycles from transfer to out_valid when there is no stall.
REQ-020 Pipeline advance: adv = !out_valid || out_ready; in_ready = adv, combinational.
REQ-021 When adv = 0, all stage registers, including valid bits, hold; bubbles are not collapsed.
REQ-022 When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
REQ-023 Throughput is one result per cycle while out_ready = 1.
REQ-024 out_sum, out_carry, out_ovf and out_zero are registered and stable while out_valid && !out_ready.
REQ-025 out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' = B for add and ~B for sub; A and B' travel with the operation.
REQ-026 out_zero is derived from the final registered sum, not from partial chunks.
REQ-027 Simultaneous output accept and input transfer in one cycle is legal and loses nothing.
REQ-028 Results emerge in strict input order.
REQ-029 Outputs are undefined-free; data registers never propagate X after reset.

Reset
REQ-030 On rst_n low, all valid bits clear immediately: out_valid = 0; in_ready = 1 once out_valid = 0.
REQ-031 On rst_n low, all data, carry and flag registers reset to 0: out_sum = 0, out_carry = 0, out_ovf = 0, out_zero = 0.
REQ-032 A reset mid-operation discards every in-flight operation; no partial result is ever presented.
REQ-033 Reset deassertion is synchronised externally; the block first accepts on the first clk edge with rst_n high.

Structure
REQ-034 Package adder_pkg holds the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
REQ-035 Package adder_pkg holds the default WIDTH and STAGES constants.
REQ-036 Sub-module adder_slice: CW-bit adder of a, b and cin, producing sum and cout; it is combinational and instantiated STAGES times via generate.
REQ-037 Stage registers and the valid chain live in pipelined_adder, and there are no other sub-modules.

Verification
REQ-038 Defaults, A = 0xFFFFFFFF + B = 0x00000001, add -> after 4 cycles sum = 0x00000000, carry = 1, ovf = 0, zero = 1 (full carry ripple across all stages).
REQ-039 A = 0x7FFFFFFF + B = 0x00000001 -> sum = 0x80000000, carry = 0, ovf = 1; sub A = 0x80000000 - B = 0x00000001 -> sum = 0x7FFFFFFF, carry = 1, ovf = 1.
REQ-040 Stream 100 back-to-back random ops with out_ready = 1 -> one result per cycle, in order, all matching the reference model.
REQ-041 Hold out_ready = 0 for 10 cycles mid-stream -> in_ready = 0, out_* stable, no op lost or duplicated after release.
REQ-042 Assert rst_n low with 3 ops in flight -> out_valid = 0 immediately and no stale result after reset release.
REQ-043 Repeat REQ-038 and REQ-040 with WIDTH = 16, STAGES = 1 and WIDTH = 64, STAGES = 8 -> latency 1 and 8 respectively, results correct.
